// File: rtl/field_cfg_loader.sv
// Field configuration loader: on a start pulse, copies one preset pattern row by row
// from the synchronous configuration ROM into the field memory write port.
`timescale 1ns/1ps

package field_cfg_pkg;
    typedef enum logic [1:0] {
        NO_REQ = 2'd0,
        CFG_1  = 2'd1,
        CFG_2  = 2'd2
    } load_cfg_req_t;
endpackage

module field_cfg_loader
    import field_cfg_pkg::*;
#(
    parameter int FIELD_W = 32,
    parameter int FIELD_H = 32,
    parameter int ROW_AW  = $clog2(FIELD_H),
    parameter int ROM_AW  = $clog2(2*FIELD_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_go,
    input  load_cfg_req_t       i_load_cfg_req,
    output logic                o_is_loading,
    output logic                o_load_done,
    output logic                o_rom_en,
    output logic [ROM_AW-1:0]   o_rom_addr,
    input  logic [FIELD_W-1:0]  i_rom_data,
    output logic                o_wr_en,
    output logic [ROW_AW-1:0]   o_wr_addr,
    output logic [FIELD_W-1:0]  o_wr_data,
    input  logic                i_wr_ready
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [ROW_AW-1:0] LAST_ROW  = ROW_AW'(FIELD_H - 1);
    localparam logic [ROW_AW-1:0] ROW_ONE   = ROW_AW'(1'b1);
    localparam logic [ROW_AW-1:0] ROW_ZERO  = {ROW_AW{1'b0}};
    localparam logic [ROM_AW-1:0] CFG1_BASE = {ROM_AW{1'b0}};
    localparam logic [ROM_AW-1:0] CFG2_BASE = ROM_AW'(FIELD_H);

    logic [2:0]          state_q, state_d;
    logic [ROW_AW-1:0]   row_q, row_d;
    load_cfg_req_t       req_q, req_d;
    logic                rom_en_q, rom_en_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ROW_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [FIELD_W-1:0]  wr_data_q, wr_data_d;
    logic                is_loading_q, is_loading_d;
    logic                load_done_q, load_done_d;

    logic                go_accept_s;
    logic                wr_accept_s;
    logic [ROM_AW-1:0]   base_s;

    // Only a real preset starts a copy; NO_REQ pulses are dropped.
    assign go_accept_s = i_go && ((i_load_cfg_req == CFG_1) || (i_load_cfg_req == CFG_2));
    assign wr_accept_s = wr_en_q && i_wr_ready;
    assign base_s      = (req_d == CFG_2) ? CFG2_BASE : CFG1_BASE;

    // Sequencer next-state: state, row counter and latched request.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (go_accept_s) begin
                    state_d = ST_READ;
                    req_d   = i_load_cfg_req;
                    row_d   = ROW_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_accept_s) begin
                    if (row_q == LAST_ROW) begin
                        state_d = ST_DONE;
                        row_d   = ROW_ZERO;
                    end else begin
                        state_d = ST_READ;
                        row_d   = row_q + ROW_ONE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = ROW_ZERO;
                req_d   = NO_REQ;
            end
        endcase
    end

    // Output next-values decoded from the upcoming state so every output leaves a flop.
    always_comb begin
        rom_en_d     = (state_d == ST_READ);
        wr_en_d      = (state_d == ST_WRITE);
        is_loading_d = (state_d != ST_IDLE);
        load_done_d  = (state_d == ST_DONE);
        if (state_d == ST_READ) begin
            rom_addr_d = base_s + ROM_AW'(row_d);
        end else begin
            rom_addr_d = rom_addr_q;
        end
        if (state_d == ST_WRITE) begin
            wr_addr_d = row_d;
        end else begin
            wr_addr_d = wr_addr_q;
        end
        // ROM data is valid exactly during CAPTURE; it is held through any write stall.
        if (state_q == ST_CAPTURE) begin
            wr_data_d = i_rom_data;
        end else begin
            wr_data_d = wr_data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= ROW_ZERO;
            req_q        <= NO_REQ;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= {ROM_AW{1'b0}};
            wr_en_q      <= 1'b0;
            wr_addr_q    <= ROW_ZERO;
            wr_data_q    <= {FIELD_W{1'b0}};
            is_loading_q <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            req_q        <= req_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            is_loading_q <= is_loading_d;
            load_done_q  <= load_done_d;
        end
    end

    assign o_is_loading = is_loading_q;
    assign o_load_done  = load_done_q;
    assign o_rom_en     = rom_en_q;
    assign o_rom_addr   = rom_addr_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;

endmodule
